// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default geometry for the instruction fetch controller.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HALT = 2'd2} state_t;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 32;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with reset value, redirect load and wrapping increment.
module fetch_pc_reg #(
  parameter int ADDR_W = 6,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);
  always_ff @(posedge clk)
    pc <= rst ? RESET_PC : load ? load_addr : inc ? pc + ADDR_W'(1) : pc;
endmodule

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: fetch sequencer with one-entry valid/ready output slot, redirect and halt.
// Define FETCH_PERF_CNT_EN to build the saturating accepted-instruction counter.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              halted,
  output logic [15:0]       perf_fetch_cnt
);
  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              slot_free, inc;

  assign slot_free = !out_valid || out_ready;
  assign inc       = state == FETCH && !redirect_valid && slot_free;
  assign im_addr   = pc;
  assign halted    = state == HALT;

  fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk), .rst(rst), .load(redirect_valid), .inc(inc),
    .load_addr(redirect_addr), .pc(pc)
  );

  // Redirect flushes the slot in every state; a load always wins over retiring the old entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      if (inc) begin
        out_valid <= 1'b1;
        out_instr <= im_rdata;
        out_pc    <= pc;
      end else if (redirect_valid || out_ready) out_valid <= 1'b0;
      state <= state == IDLE  ? (start ? FETCH : IDLE)
             : state == FETCH ? (inc && im_rdata == HALT_WORD ? HALT : FETCH)
             : (redirect_valid || start ? FETCH : HALT);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (out_valid && out_ready && !redirect_valid && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  assign perf_fetch_cnt = cnt;
`else
  assign perf_fetch_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed plus randomized checks of instr_fetch_ctrl against a behavioural model.
module tb_instr_fetch_ctrl;
  localparam logic [31:0] HW = 32'hFFFF_FFFF;
  logic        clk = 0, rst, start, out_ready, redirect_valid, out_valid, halted;
  logic [5:0]  im_addr, out_pc, redirect_addr;
  logic [31:0] im_rdata, out_instr;
  logic [15:0] perf_fetch_cnt;
  logic [31:0] mem [64];
  int n_chk = 0, n_fail = 0;
  int m_state = 0, m_pc = 0, m_opc = 0, m_cnt = 0;
  bit m_valid = 0;
  logic [31:0] m_instr = 0;

  always #5 clk = ~clk;
  assign im_rdata = mem[im_addr];

  instr_fetch_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .im_addr(im_addr), .im_rdata(im_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halted(halted),
    .perf_fetch_cnt(perf_fetch_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: 0 idle, 1 fetching, 2 halted; one step per rising edge from the sampled inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_pc = 0; m_valid = 0; m_instr = 0; m_opc = 0; m_cnt = 0;
    end else begin
      if (m_valid && out_ready && !redirect_valid && m_cnt < 65535) m_cnt++;
      if (m_state == 0) begin
        if (redirect_valid) m_pc = redirect_addr;
        if (start) m_state = 1;
      end else if (m_state == 1) begin
        if (redirect_valid) begin
          m_valid = 0; m_pc = redirect_addr;
        end else if (!m_valid || out_ready) begin
          m_instr = mem[m_pc]; m_opc = m_pc; m_valid = 1; m_pc = (m_pc + 1) % 64;
          if (m_instr == HW) m_state = 2;
        end
      end else begin
        if (redirect_valid) begin
          m_pc = redirect_addr; m_valid = 0; m_state = 1;
        end else begin
          if (out_ready) m_valid = 0;
          if (start) m_state = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("im_addr", {26'b0, im_addr}, m_pc);
    chk("halted", {31'b0, halted}, {31'b0, m_state == 2});
    if (m_valid) begin
      chk("out_instr", out_instr, m_instr);
      chk("out_pc", {26'b0, out_pc}, m_opc);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf", {16'b0, perf_fetch_cnt}, m_cnt);
`else
    chk("perf", {16'b0, perf_fetch_cnt}, 0);
`endif
  end

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = k + 100;
    rst = 1; start = 0; out_ready = 0; redirect_valid = 0; redirect_addr = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_addr", {26'b0, im_addr}, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    rst = 0; start = 1; out_ready = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    chk("first_valid", {31'b0, out_valid}, 1);
    chk("first_pc", {26'b0, out_pc}, 0);
    chk("first_instr", out_instr, 100);
    @(negedge clk);
    chk("second_instr", out_instr, 101);
    repeat (4) @(negedge clk);
    chk("pc5", {26'b0, out_pc}, 5);
    out_ready = 0;
    repeat (3) @(negedge clk);
    chk("stall_pc", {26'b0, out_pc}, 5);
    chk("stall_instr", out_instr, 105);
    chk("stall_addr", {26'b0, im_addr}, 6);
    out_ready = 1;
    @(negedge clk);
    chk("release_pc", {26'b0, out_pc}, 6);
    repeat (4) @(negedge clk);
    chk("pc10", {26'b0, out_pc}, 10);
    out_ready = 0; redirect_valid = 1; redirect_addr = 40;
    @(negedge clk);
    chk("flush_valid", {31'b0, out_valid}, 0);
    redirect_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("redir_pc40", {26'b0, out_pc}, 40);
    @(negedge clk);
    chk("redir_pc41", {26'b0, out_pc}, 41);
    redirect_valid = 1; redirect_addr = 62;
    @(negedge clk); redirect_valid = 0;
    repeat (2) @(negedge clk);
    chk("wrap_pc63", {26'b0, out_pc}, 63);
    chk("wrap_instr63", out_instr, 163);
    @(negedge clk);
    chk("wrap_pc0", {26'b0, out_pc}, 0);
    chk("wrap_instr0", out_instr, 100);
    redirect_valid = 1; redirect_addr = 1; mem[3] = HW;
    @(negedge clk); redirect_valid = 0;
    repeat (3) @(negedge clk);
    chk("halt_pc", {26'b0, out_pc}, 3);
    chk("halt_instr", out_instr, HW);
    chk("halt_flag", {31'b0, halted}, 1);
    @(negedge clk);
    chk("halt_drained", {31'b0, out_valid}, 0);
    @(negedge clk);
    chk("halt_idle", {31'b0, out_valid}, 0);
    start = 1;
    @(negedge clk); start = 0;
    chk("resume_halted", {31'b0, halted}, 0);
    @(negedge clk);
    chk("resume_pc", {26'b0, out_pc}, 4);
    chk("resume_instr", out_instr, 104);
    mem[3] = 103; out_ready = 0;
    @(negedge clk); rst = 1;
    @(negedge clk);
    chk("mid_rst_valid", {31'b0, out_valid}, 0);
    chk("mid_rst_addr", {26'b0, im_addr}, 0);
    chk("mid_rst_perf", {16'b0, perf_fetch_cnt}, 0);
    rst = 0; start = 1; out_ready = 1;
    @(negedge clk); start = 0;
    @(negedge clk);
    chk("restart_pc", {26'b0, out_pc}, 0);
    repeat (4) @(negedge clk);
    chk("perf_pc4", {26'b0, out_pc}, 4);
    redirect_valid = 1; redirect_addr = 20;
    @(negedge clk);
    redirect_valid = 0; out_ready = 0;
`ifdef FETCH_PERF_CNT_EN
    chk("perf_four", {16'b0, perf_fetch_cnt}, 4);
`else
    chk("perf_off", {16'b0, perf_fetch_cnt}, 0);
`endif
    mem[20] = HW; mem[50] = HW;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      rst            = $urandom_range(0, 99) == 0;
      out_ready      = $urandom_range(0, 3) != 0;
      redirect_valid = $urandom_range(0, 9) == 0;
      redirect_addr  = 6'($urandom_range(0, 63));
      start          = $urandom_range(0, 15) == 0;
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
